// File: rtl/mp_adder_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mp_adder_seq
//  Description : Multi-precision add sequencer. Adds two N*K-bit operands
//                with a single N-bit add slice, one chunk per clock, least
//                significant chunk first. The inter-chunk carry is held in a
//                register. Start/busy/done handshake toward the issuer.
//
//  Parameters  : N  chunk width in bits (>= 1)
//                K  number of chunks (>= 1); operand width W = N*K
//
//  Ports       : clk    system clock, rising edge
//                rst    synchronous reset, active-high
//                start  job request, sampled only in IDLE
//                sub    (MP_ADDER_SUB_MODE_EN only) 1 = compute a - b
//                a, b   operands, captured on the accepting edge
//                busy   high while chunks are being processed
//                done   one-cycle pulse when sum/cout are valid
//                sum    result, low W bits
//                cout   carry out of the most significant chunk
//                       (in subtract mode: 1 = no borrow, a >= b)
//
//  Options     : `define MP_ADDER_SUB_MODE_EN adds the sub input and
//                subtraction (a + ~b + 1). Default build is add only.
//
//  Revision    : 1.0  initial release
// ============================================================================
module mp_adder_seq #(
    parameter int N = 4,
    parameter int K = 4
) (
    input  wire logic           clk,
    input  wire logic           rst,
    input  wire logic           start,
`ifdef MP_ADDER_SUB_MODE_EN
    input  wire logic           sub,
`endif
    input  wire logic [N*K-1:0] a,
    input  wire logic [N*K-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [N*K-1:0]      sum,
    output logic                cout
);

    localparam int c_W     = N * K;
    localparam int c_IDX_W = (K > 1) ? $clog2(K) : 1;
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(K - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_W-1:0]       r_a;
    logic [c_W-1:0]       r_b;
    logic [c_IDX_W-1:0]   r_idx;
    logic                 r_carry;
`ifdef MP_ADDER_SUB_MODE_EN
    logic                 r_sub;
`endif

    logic [N-1:0]         w_a_chunk;
    logic [N-1:0]         w_b_chunk;
    logic [N:0]           w_slice;
    logic                 w_carry_init;

    // Operand chunk currently addressed by the index counter.
    assign w_a_chunk = r_a[r_idx*N +: N];

`ifdef MP_ADDER_SUB_MODE_EN
    // Subtraction is a + ~b + 1: invert every b chunk, seed the carry with 1.
    assign w_b_chunk    = r_sub ? ~r_b[r_idx*N +: N] : r_b[r_idx*N +: N];
    assign w_carry_init = sub;
`else
    assign w_b_chunk    = r_b[r_idx*N +: N];
    assign w_carry_init = 1'b0;
`endif

    // The single N-bit add slice, widened by one bit to expose the carry.
    assign w_slice = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{N{1'b0}}, r_carry};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
`ifdef MP_ADDER_SUB_MODE_EN
            r_sub   <= 1'b0;
`endif
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
`ifdef MP_ADDER_SUB_MODE_EN
                        r_sub   <= sub;
`endif
                        r_idx   <= '0;
                        r_carry <= w_carry_init;
                        sum     <= '0;
                        cout    <= 1'b0;
                        busy    <= 1'b1;
                        r_state <= RUN;
                    end
                end

                RUN: begin
                    sum[r_idx*N +: N] <= w_slice[N-1:0];
                    r_carry           <= w_slice[N];
                    if (r_idx == c_IDX_LAST) begin
                        cout    <= w_slice[N];
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx + c_IDX_W'(1);
                    end
                end

                DONE: begin
                    // start is deliberately ignored here; the next job can
                    // only be accepted from IDLE.
                    done    <= 1'b0;
                    r_state <= IDLE;
                end

                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mp_adder_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mp_adder_seq
//  Description : Self-checking bench for mp_adder_seq (N=4, K=4). Directed
//                jobs plus random jobs, compared against an arithmetic
//                reference of the whole-width add/subtract.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mp_adder_seq;

    localparam int N = 4;
    localparam int K = 4;
    localparam int W = N * K;

    logic         clk;
    logic         rst;
    logic         start;
`ifdef MP_ADDER_SUB_MODE_EN
    logic         sub;
`endif
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_cmp;
    int n_fail;

    mp_adder_seq #(.N(N), .K(K)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
`ifdef MP_ADDER_SUB_MODE_EN
        .sub   (sub),
`endif
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: whole-width arithmetic. Add gives a W+1 bit sum; subtract
    // wraps modulo 2^W and reports "no borrow" as the carry.
    function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic msub);
        logic [W:0] r;
        if (msub) begin
            r[W-1:0] = ma - mb;
            r[W]     = (ma >= mb);
        end else begin
            r = {1'b0, ma} + {1'b0, mb};
        end
        return r;
    endfunction

    // Runs one job from IDLE (caller sits 1 time unit after a rising edge).
    // With noise=1, start stays high with junk operands during RUN and DONE.
    task automatic run_job(input logic [W-1:0] ja, input logic [W-1:0] jb,
                           input logic jsub, input bit noise);
        logic [W:0]   exp;
        logic [W-1:0] mask;
        exp   = model(ja, jb, jsub);
        start = 1'b1;
        a     = ja;
        b     = jb;
`ifdef MP_ADDER_SUB_MODE_EN
        sub   = jsub;
`endif
        @(posedge clk); #1;
        start = noise;
        if (noise) begin
            a = 16'h1234;
            b = W'($urandom);
`ifdef MP_ADDER_SUB_MODE_EN
            sub = ~jsub;
`endif
        end
        chk("accept_busy", 64'(busy), 64'd1);
        chk("accept_done", 64'(done), 64'd0);
        chk("accept_sum_cleared", 64'(sum), 64'd0);
        chk("accept_cout_cleared", 64'(cout), 64'd0);
        for (int i = 1; i <= K; i++) begin
            @(posedge clk); #1;
            if (i < K) begin
                mask = (W'(1) << (i * N)) - W'(1);
                chk("run_busy", 64'(busy), 64'd1);
                chk("run_done", 64'(done), 64'd0);
                chk("run_partial_sum", 64'(sum & mask), 64'(exp[W-1:0] & mask));
            end else begin
                chk("done_busy", 64'(busy), 64'd0);
                chk("done_pulse", 64'(done), 64'd1);
                chk("done_sum", 64'(sum), 64'(exp[W-1:0]));
                chk("done_cout", 64'(cout), 64'(exp[W]));
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_done", 64'(done), 64'd0);
        chk("idle_sum_hold", 64'(sum), 64'(exp[W-1:0]));
        chk("idle_cout_hold", 64'(cout), 64'(exp[W]));
        @(posedge clk); #1;
        chk("idle2_busy", 64'(busy), 64'd0);
        chk("idle2_done", 64'(done), 64'd0);
        chk("idle2_sum_hold", 64'(sum), 64'(exp[W-1:0]));
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        start  = 1'b0;
        a      = '0;
        b      = '0;
`ifdef MP_ADDER_SUB_MODE_EN
        sub    = 1'b0;
`endif
        @(posedge clk); @(posedge clk); #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_sum", 64'(sum), 64'd0);
        chk("reset_cout", 64'(cout), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed jobs.
        run_job(16'h0001, 16'h0002, 1'b0, 1'b0);
        run_job(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run_job(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
        run_job(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        // Start pulses during RUN and DONE must be ignored.
        run_job(16'h0001, 16'h0002, 1'b0, 1'b1);

        // Reset asserted on the 2nd RUN edge aborts the job.
        start = 1'b1;
        a     = 16'hABCD;
        b     = 16'h1111;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_sum", 64'(sum), 64'd0);
        chk("abort_cout", 64'(cout), 64'd0);
        for (int i = 0; i < K + 2; i++) begin
            @(posedge clk); #1;
            chk("abort_no_done", 64'(done), 64'd0);
            chk("abort_no_busy", 64'(busy), 64'd0);
        end
        run_job(16'h1234, 16'h4321, 1'b0, 1'b0);

`ifdef MP_ADDER_SUB_MODE_EN
        run_job(16'h0005, 16'h0007, 1'b1, 1'b0);
        run_job(16'h0007, 16'h0005, 1'b1, 1'b0);
        run_job(16'h8000, 16'h8000, 1'b1, 1'b0);
`endif

        // Random jobs.
        for (int j = 0; j < 24; j++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'b0;
`ifdef MP_ADDER_SUB_MODE_EN
            rs = 1'($urandom_range(0, 1));
`endif
            run_job(ra, rb, rs, bit'(j % 3 == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mp_adder_seq.md
Name: mp_adder_seq

Overview:
- Multi-precision add sequencer: computes the sum of two N*K-bit operands using one N-bit add slice, processing one N-bit chunk per clock, LSB chunk first.
- Carry is held in a register between chunks.
- Sits in front of wide arithmetic consumers where a full-width combinational adder is too costly. Start/busy/done handshake toward the issuing controller.

Parameters:
- N, 4, chunk width in bits (>=1); width of the single add slice.
- K, 4, number of chunks (>=1); total operand width W = N*K.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request; sampled only in IDLE.
- a  input  N*K  operand A; captured on accepted start.
- b  input  N*K  operand B; captured on accepted start.
- busy  output  1  high while chunks are being processed (RUN).
- done  output  1  one-cycle pulse when result is valid.
- sum  output  N*K  result, low W bits.
- cout  output  1  carry out of the most significant chunk.

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-high (rst sampled on the rising edge of clk).
- Reset values:
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Internal carry=0, chunk index=0, operand registers=0.
- Reset mid-operation: aborts immediately to reset values. No done pulse for the aborted job.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge → latch a, b.
  - Set idx=0, carry=0, sum=0, cout=0.
  - Go to RUN.
- RUN, at each edge:
  - Compute {c, s} = {0, a_i} + {0, b_i} + carry, with (N+1)-bit width, where a_i = a_reg[i*N +: N].
  - Write s to sum[i*N +: N] and set carry=c.
  - If idx=K-1: cout=c, go to DONE. Otherwise idx++.
- DONE: done=1 for exactly this cycle; next edge → IDLE.
- Latency: the start-accepting edge is edge 0.
  - Chunks are written on edges 1..K.
  - done is high in the cycle after edge K. K=4 → done visible after the 4th edge following acceptance.
- busy=1 exactly in RUN; done=1 exactly in DONE; busy and done are never both high.
- Back-to-back jobs: start asserted in DONE is ignored. The earliest new acceptance is the first IDLE cycle, so throughput is one job per K+2 cycles.
- start in RUN or DONE: ignored. The a/b inputs may change freely after acceptance.
- sum/cout: hold the last completed result until the next accepted start clears them. sum is partially updated (chunk by chunk) during RUN and is only valid when done=1 or later in IDLE.
- Overflow: wraps modulo 2^W; cout carries the overflow bit.
- K=1: single RUN cycle, equivalent to a registered N-bit add.
- Index counter width: max(1, $clog2(K)).

Optional Feature:
- Macro: MP_ADDER_SUB_MODE_EN.
- Defined:
  - Extra input port sub (1 bit), captured with the operands on accepted start.
  - sub=1 computes a - b: every chunk uses ~b_i, and carry is initialised to 1 at acceptance.
  - In subtraction, cout=1 means no borrow (a >= b unsigned).
  - sub=0 behaves identically to add mode.
- Undefined: no sub port; add only, with carry initialised to 0.

Test Plan (N=4, K=4):
- Simple add: a=0x0001, b=0x0002, start pulse → busy for 4 cycles, done pulse on the 5th cycle after acceptance; sum=0x0003, cout=0.
- Full carry ripple: a=0xFFFF, b=0x0001 → sum=0x0000, cout=1; carry propagates through all 4 chunks.
- Mixed values: a=0x0F0F, b=0x00F1 → sum=0x1000, cout=0. Then a=0xFFFF, b=0xFFFF → sum=0xFFFE, cout=1; each result is held in IDLE until the next start.
- Ignored start: a start pulse with a=0x1234 during RUN, and another in DONE, are ignored; first job result unchanged; exactly one done pulse per accepted start.
- Reset mid-run: rst asserted on the 2nd RUN edge → next cycle busy=0, done=0, sum=0, cout=0; no done pulse. A new start after reset yields a correct result.
- MP_ADDER_SUB_MODE_EN: sub=1, a=0x0005, b=0x0007 → sum=0xFFFE, cout=0. Then a=0x0007, b=0x0005 → sum=0x0002, cout=1.
